// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and constants for the two-port program ROM arbiter and its tag pipeline.
package rom_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_AUX   = 1'b1;

    typedef struct packed {
        logic valid;
        logic port_id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, port_id: 1'b0};

    // Grant counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_tag_pipe.sv
// Latency-matched {valid, port_id} shift register; the tail entry lines up with the
// ROM data belonging to the read that was granted ROM_LATENCY cycles earlier.
module rom_tag_pipe
    import rom_port_arbiter_pkg::*;
#(
    parameter int ROM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_tail
);

    tag_t stage_q [ROM_LATENCY];
    tag_t stage_d [ROM_LATENCY];

    // Shift one stage per cycle; stage 0 takes the tag of this cycle's grant.
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipeline registers; reset discards every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                stage_q[i] <= TAG_IDLE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_tail = stage_q[ROM_LATENCY-1];

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one synchronous program ROM between instruction fetch
// (port 0) and an auxiliary reader (port 1). Optional grant counters: ROM_ARB_STATS_EN.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  REQ0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    output logic                  GNT0,
    output logic                  RVALID0,
    output logic [DATA_WIDTH-1:0] RDATA0,
    input  logic                  REQ1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    output logic                  GNT1,
    output logic                  RVALID1,
    output logic [DATA_WIDTH-1:0] RDATA1,
`ifdef ROM_ARB_STATS_EN
    input  logic                  CLR_STATS,
    output logic [15:0]           GNT_CNT0,
    output logic [15:0]           GNT_CNT1,
`endif
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    input  logic [DATA_WIDTH-1:0] ROM_DATA
);

    logic                  gnt0_s, gnt1_s;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    tag_t                  tag_in_s, tag_tail_s;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Arbitration: on contention the port that did not win last time gets the ROM.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!RESETN) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (REQ0 && REQ1) begin
            gnt0_s = (last_q == PORT_AUX);
            gnt1_s = (last_q == PORT_FETCH);
        end else begin
            gnt0_s = REQ0;
            gnt1_s = REQ1;
        end
    end

    // Grant side effects: steer the address, remember the winner, launch a tag.
    always_comb begin
        last_d      = last_q;
        addr_hold_d = addr_hold_q;
        tag_in_s    = TAG_IDLE;
        if (gnt0_s) begin
            last_d      = PORT_FETCH;
            addr_hold_d = ADDR0;
            tag_in_s    = '{valid: 1'b1, port_id: PORT_FETCH};
        end else if (gnt1_s) begin
            last_d      = PORT_AUX;
            addr_hold_d = ADDR1;
            tag_in_s    = '{valid: 1'b1, port_id: PORT_AUX};
        end else begin
            tag_in_s    = TAG_IDLE;
        end
    end

    // The ROM sees the granted address directly, otherwise the last one granted.
    assign ROM_ADDR = addr_hold_d;
    assign GNT0     = gnt0_s;
    assign GNT1     = gnt1_s;

    rom_tag_pipe #(
        .ROM_LATENCY (ROM_LATENCY)
    ) u_tag_pipe (
        .clk      (CLK),
        .rst_n    (RESETN),
        .tag_in   (tag_in_s),
        .tag_tail (tag_tail_s)
    );

    // Route returning ROM data to the port named by the tail tag.
    always_comb begin
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (tag_tail_s.valid) begin
            if (tag_tail_s.port_id == PORT_FETCH) begin
                rvalid0_d = 1'b1;
                rdata0_d  = ROM_DATA;
            end else begin
                rvalid1_d = 1'b1;
                rdata1_d  = ROM_DATA;
            end
        end else begin
            rvalid0_d = 1'b0;
            rvalid1_d = 1'b0;
        end
    end

    // Arbiter state and registered read-return outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            last_q      <= PORT_AUX;
            addr_hold_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            last_q      <= last_d;
            addr_hold_q <= addr_hold_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign RVALID0 = rvalid0_q;
    assign RVALID1 = rvalid1_q;
    assign RDATA0  = rdata0_q;
    assign RDATA1  = rdata1_q;

`ifdef ROM_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // A clear on the same edge as a grant takes priority over the increment.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (CLR_STATS) begin
            cnt0_d = 16'h0000;
            cnt1_d = 16'h0000;
        end else begin
            cnt0_d = gnt0_s ? sat_inc16(cnt0_q) : cnt0_q;
            cnt1_d = gnt1_s ? sat_inc16(cnt1_q) : cnt1_q;
        end
    end

    // Grant counter registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign GNT_CNT0 = cnt0_q;
    assign GNT_CNT1 = cnt1_q;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench: two arbiters (ROM latency 1 and 3) driven with identical stimulus,
// each compared every cycle against a queue-based model of outstanding reads.
`timescale 1ns/1ps
module tb_rom_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic       CLK    = 1'b0;
    logic       RESETN = 1'b0;
    logic       REQ0   = 1'b0;
    logic       REQ1   = 1'b0;
    logic [7:0] ADDR0  = 8'h00;
    logic [7:0] ADDR1  = 8'h00;

    logic       gnt0_a, gnt1_a, rv0_a, rv1_a;
    logic       gnt0_b, gnt1_b, rv0_b, rv1_b;
    logic [7:0] rd0_a, rd1_a, rom_addr_a, rom_data_a;
    logic [7:0] rd0_b, rd1_b, rom_addr_b, rom_data_b;
`ifdef ROM_ARB_STATS_EN
    logic        CLR_STATS = 1'b0;
    logic [15:0] cnt0_a, cnt1_a, cnt0_b, cnt1_b;
`endif

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return (a * 8'd37) ^ 8'h5A;
    endfunction

    // Behavioural ROMs with registered output, latency 1 and 3.
    logic [7:0] rom_a_q;
    logic [7:0] rom_b_q [3];
    always @(posedge CLK) begin
        rom_a_q    <= rom_f(rom_addr_a);
        rom_b_q[0] <= rom_f(rom_addr_b);
        rom_b_q[1] <= rom_b_q[0];
        rom_b_q[2] <= rom_b_q[1];
    end
    assign rom_data_a = rom_a_q;
    assign rom_data_b = rom_b_q[2];

    rom_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .ROM_LATENCY(LAT_A)) u_dut_a (
        .CLK(CLK), .RESETN(RESETN),
        .REQ0(REQ0), .ADDR0(ADDR0), .GNT0(gnt0_a), .RVALID0(rv0_a), .RDATA0(rd0_a),
        .REQ1(REQ1), .ADDR1(ADDR1), .GNT1(gnt1_a), .RVALID1(rv1_a), .RDATA1(rd1_a),
`ifdef ROM_ARB_STATS_EN
        .CLR_STATS(CLR_STATS), .GNT_CNT0(cnt0_a), .GNT_CNT1(cnt1_a),
`endif
        .ROM_ADDR(rom_addr_a), .ROM_DATA(rom_data_a)
    );

    rom_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .ROM_LATENCY(LAT_B)) u_dut_b (
        .CLK(CLK), .RESETN(RESETN),
        .REQ0(REQ0), .ADDR0(ADDR0), .GNT0(gnt0_b), .RVALID0(rv0_b), .RDATA0(rd0_b),
        .REQ1(REQ1), .ADDR1(ADDR1), .GNT1(gnt1_b), .RVALID1(rv1_b), .RDATA1(rd1_b),
`ifdef ROM_ARB_STATS_EN
        .CLR_STATS(CLR_STATS), .GNT_CNT0(cnt0_b), .GNT_CNT1(cnt1_b),
`endif
        .ROM_ADDR(rom_addr_b), .ROM_DATA(rom_data_b)
    );

    // Reference model: outstanding reads as {grant cycle, port, address}.
    typedef struct {
        int         gc;
        int         port;
        logic [7:0] addr;
    } pend_t;

    pend_t      pend[$];
    int         cyc;
    int         last_g;
    int         g_seen;
    logic [7:0] held;
    logic [7:0] exp_rd [2][2];
    int         exp_cnt [2];
    int         checks;
    int         errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        last_g = 1;
        held   = 8'h00;
        for (int d = 0; d < 2; d++) begin
            exp_rd[d][0] = 8'h00;
            exp_rd[d][1] = 8'h00;
        end
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
    endtask

    // One clock cycle: drive, predict, compare every output of both DUTs, then advance the model.
    task automatic cycle(input logic r0, input logic [7:0] a0, input logic r1,
                         input logic [7:0] a1, input logic clr);
        int         g;
        logic [7:0] ea;
        logic [1:0] rva, rvb;
        @(negedge CLK);
        REQ0 = r0; ADDR0 = a0; REQ1 = r1; ADDR1 = a1;
`ifdef ROM_ARB_STATS_EN
        CLR_STATS = clr;
`endif
        #1;
        if (r0 && r1)  g = (last_g == 0) ? 1 : 0;
        else if (r0)   g = 0;
        else if (r1)   g = 1;
        else           g = -1;
        ea = (g == 0) ? a0 : ((g == 1) ? a1 : held);
        rva = 2'b00;
        rvb = 2'b00;
        foreach (pend[i]) begin
            if (pend[i].gc + LAT_A + 1 == cyc) begin
                rva[pend[i].port] = 1'b1;
                exp_rd[0][pend[i].port] = rom_f(pend[i].addr);
            end
            if (pend[i].gc + LAT_B + 1 == cyc) begin
                rvb[pend[i].port] = 1'b1;
                exp_rd[1][pend[i].port] = rom_f(pend[i].addr);
            end
        end
        chk("gnt0_a", 32'(gnt0_a), 32'(g == 0));
        chk("gnt1_a", 32'(gnt1_a), 32'(g == 1));
        chk("gnt0_b", 32'(gnt0_b), 32'(g == 0));
        chk("gnt1_b", 32'(gnt1_b), 32'(g == 1));
        chk("rom_addr_a", 32'(rom_addr_a), 32'(ea));
        chk("rom_addr_b", 32'(rom_addr_b), 32'(ea));
        chk("rvalid0_a", 32'(rv0_a), 32'(rva[0]));
        chk("rvalid1_a", 32'(rv1_a), 32'(rva[1]));
        chk("rvalid0_b", 32'(rv0_b), 32'(rvb[0]));
        chk("rvalid1_b", 32'(rv1_b), 32'(rvb[1]));
        chk("rdata0_a", 32'(rd0_a), 32'(exp_rd[0][0]));
        chk("rdata1_a", 32'(rd1_a), 32'(exp_rd[0][1]));
        chk("rdata0_b", 32'(rd0_b), 32'(exp_rd[1][0]));
        chk("rdata1_b", 32'(rd1_b), 32'(exp_rd[1][1]));
`ifdef ROM_ARB_STATS_EN
        chk("gnt_cnt0_a", 32'(cnt0_a), 32'(exp_cnt[0]));
        chk("gnt_cnt1_a", 32'(cnt1_a), 32'(exp_cnt[1]));
        chk("gnt_cnt0_b", 32'(cnt0_b), 32'(exp_cnt[0]));
        chk("gnt_cnt1_b", 32'(cnt1_b), 32'(exp_cnt[1]));
        if (clr) begin
            exp_cnt[0] = 0;
            exp_cnt[1] = 0;
        end else if (g >= 0 && exp_cnt[g] < 65535) begin
            exp_cnt[g]++;
        end
`endif
        if (g >= 0) begin
            pend.push_back('{gc: cyc, port: g, addr: ea});
            last_g = g;
            held   = ea;
        end
        while (pend.size() > 0 && pend[0].gc + LAT_B + 1 <= cyc) void'(pend.pop_front());
        g_seen = g;
        cyc++;
    endtask

    // Assert reset mid-cycle with both requests high; everything must clear at once.
    task automatic do_reset();
        @(negedge CLK);
        REQ0 = 1'b1; REQ1 = 1'b1; RESETN = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt0", 32'(gnt0_a | gnt0_b), 32'd0);
        chk("rst_gnt1", 32'(gnt1_a | gnt1_b), 32'd0);
        chk("rst_rvalid", 32'({rv0_a, rv1_a, rv0_b, rv1_b}), 32'd0);
        chk("rst_rdata", 32'({rd0_a, rd1_a, rd0_b, rd1_b}), 32'd0);
        chk("rst_rom_addr", 32'({rom_addr_a, rom_addr_b}), 32'd0);
        @(negedge CLK);
        REQ0 = 1'b0; REQ1 = 1'b0; RESETN = 1'b1;
    endtask

    typedef struct packed {
        logic       r0;
        logic [7:0] a0;
        logic       r1;
        logic [7:0] a1;
        logic       g0;
        logic       g1;
        logic [7:0] ra;
    } vec_t;

    vec_t vecs [8];

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        g_seen = -1;
        model_reset();

        //             r0    a0     r1    a1     g0    g1    rom_addr
        vecs[0] = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05};
        vecs[2] = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b0, 1'b1, 8'h20};
        vecs[3] = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 1'b0, 8'h10};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 8'h33};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h34, 1'b0, 1'b1, 8'h34};
        vecs[6] = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 1'b0, 8'h10};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10};

        do_reset();

        // Hand-traced arbitration table from reset.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1, 1'b0);
            chk("tbl_gnt0", 32'(gnt0_a), 32'(vecs[i].g0));
            chk("tbl_gnt1", 32'(gnt1_a), 32'(vecs[i].g1));
            chk("tbl_rom_addr", 32'(rom_addr_a), 32'(vecs[i].ra));
            if (i == 2) begin
                chk("first_read_rvalid0", 32'(rv0_a), 32'd1);
                chk("first_read_rdata0", 32'(rd0_a), 32'(rom_f(8'h05)));
            end
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Sustained contention after reset alternates starting with port 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'h10, 1'b1, 8'h20, 1'b0);
            chk("alternate", 32'(g_seen), 32'(i % 2));
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Port 1 streaming through the whole address space and wrapping.
        for (int i = 0; i < 258; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 8'(i), 1'b0);
            chk("stream_gnt1", 32'(gnt1_a & gnt1_b), 32'd1);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Idle hold of the last granted address.
        cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            chk("idle_hold", 32'(rom_addr_b), 32'h3C);
        end

        // Reset one cycle after a grant drops the in-flight read.
        cycle(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        do_reset();
        cycle(1'b1, 8'h01, 1'b1, 8'h02, 1'b0);
        chk("post_reset_port0_first", 32'(gnt0_a), 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

`ifdef ROM_ARB_STATS_EN
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 8'(i + 100), 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("stats_cnt0", 32'(cnt0_b), 32'd10);
        chk("stats_cnt1", 32'(cnt1_b), 32'd5);
        cycle(1'b1, 8'h09, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("stats_clear_wins", 32'(cnt0_a), 32'd0);
        chk("stats_clear_other", 32'(cnt1_a), 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic clr;
            clr = 1'b0;
`ifdef ROM_ARB_STATS_EN
            clr = ($urandom_range(0, 31) == 0);
`endif
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  8'($urandom), clr);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single synchronous program ROM (8-bit address, 8-bit data, registered output) between two read requesters.
  - Port 0: processor instruction fetch.
  - Port 1: secondary reader (loader/debug).
- Round-robin arbitration, one ROM access issued per cycle at most.
- Each read returns to the port that issued it, tagged through a latency-matched pipeline.
- Sits between the processor/peripheral bus masters and the ROM instance.

Parameters:
- ADDR_WIDTH, 8, ROM address width.
- DATA_WIDTH, 8, ROM data width.
- ROM_LATENCY, 1, ROM cycles from address sampled to data valid; legal 1..3.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESETN  in  1  asynchronous active-low reset.
- REQ0  in  1  port 0 read request; held until granted.
- ADDR0  in  ADDR_WIDTH  port 0 address; stable while REQ0 high.
- GNT0  out  1  port 0 request accepted this cycle (combinational).
- RVALID0  out  1  port 0 read data valid (registered).
- RDATA0  out  DATA_WIDTH  port 0 read data (registered).
- REQ1, ADDR1, GNT1, RVALID1, RDATA1: same as port 0, for port 1.
- ROM_ADDR  out  ADDR_WIDTH  address to ROM ADDR.
- ROM_DATA  in  DATA_WIDTH  data from ROM DATA.

Behaviour:
- Reset (RESETN low, asynchronous):
  - GNT0/1=0, RVALID0/1=0, RDATA0/1=0.
  - Held ROM address register=0.
  - Tag pipeline cleared.
  - Last-grant pointer=1, so port 0 wins first.
- Arbitration, each cycle, combinational:
  - Only REQ0 high -> GNT0=1.
  - Only REQ1 high -> GNT1=1.
  - Both high -> grant the port not granted last.
  - Neither -> no grant.
  - GNT0 and GNT1 are never both 1.
- Grant effects:
  - ROM_ADDR = address of the granted port in the grant cycle.
  - The requester treats GNT as an accept on the rising edge; it may present a new address or drop REQ next cycle.
  - Last-grant pointer updates on that edge.
- No grant: ROM_ADDR = held register, which holds the last granted address; ROM_ADDR never floats or glitches to an ungranted port.
- Tag pipeline:
  - ROM_LATENCY-deep shift register of {valid, port_id}, loaded on the grant edge.
  - When the tail entry is valid: ROM_DATA is registered into RDATAx of the tagged port, and RVALIDx pulses high for exactly one cycle.
  - Total latency from grant cycle t: RVALID asserted in cycle t+ROM_LATENCY+1.
- Throughput:
  - One grant per cycle sustained.
  - Back-to-back grants produce back-to-back RVALIDs in grant order.
- RDATA holding: RDATAx holds its last value when RVALIDx is low; the other port's RDATA is unaffected.
- No backpressure on read data: requesters must accept RVALID.
- Starvation bound: with both ports requesting continuously, grants alternate 0,1,0,1; the max wait is 1 cycle.
- Reset mid-operation: in-flight tags are discarded, no RVALID is produced for them, and the pointer returns to favour port 0.
- REQ deasserted without grant: permitted, no side effects.

Optional Feature:
- Macro: ROM_ARB_STATS_EN.
- Defined, adds:
  - Input CLR_STATS (1 bit).
  - Outputs GNT_CNT0, GNT_CNT1 (16 bits each): grants per port, saturating at 16'hFFFF.
  - CLR_STATS synchronous clear; on the same edge as a grant, the clear wins and the counter becomes 0.
  - Counters reset to 0 on RESETN.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Decomposition:
- Shared package:
  - Port-id constants PORT_FETCH=0, PORT_AUX=1.
  - Tag entry typedef {valid, port_id}.
  - Default widths 8/8.
- One natural sub-module: rom_tag_pipe.
  - Parameterised ROM_LATENCY-deep {valid, id} shift register.
  - Async reset.
  - Outputs the tail entry.

Test Plan:
- Single port 0 read: REQ0=1, ADDR0=8'h05 for one cycle (grant cycle t), ROM_LATENCY=1 -> GNT0=1 and ROM_ADDR=8'h05 in cycle t; in cycle t+2, RVALID0=1 for one cycle and RDATA0=ROM[5]; RVALID1 stays 0.
- Contention: both REQ held 6 cycles, ADDR0=8'h10, ADDR1=8'h20 -> grants 0,1,0,1,0,1; RVALID pattern alternates accordingly, with RDATA0=ROM[16] and RDATA1=ROM[32].
- Streaming port 1: REQ1=1 with ADDR1 incrementing 0..255 -> one grant per cycle; 256 consecutive RVALID1 pulses with RDATA1=ROM[0..255] in order, wrapping cleanly at 8'hFF->8'h00.
- Idle hold: grant ADDR0=8'h3C, then no REQ for 5 cycles -> ROM_ADDR stays 8'h3C and no RVALID.
- Reset mid-flight: grant at cycle t, assert RESETN=0 in cycle t+1 -> RVALID0/1=0 and RDATA=0 immediately; the next contention after release grants port 0 first.
- ROM_LATENCY=3 plus ROM_ARB_STATS_EN: 10 port 0 grants and 5 port 1 grants -> RVALID 4 cycles after each grant; GNT_CNT0=10, GNT_CNT1=5; CLR_STATS coinciding with a grant -> counter reads 0.
